// File: rtl/alu_issue_seq.sv
// Multi-cycle ADD/SUB/MUL/DIV issue sequencer: accept one request, wait LAT cycles, hold result until consumed.
// Optional status flags output enabled by defining ALU_ISSUE_SEQ_FLAGS_EN.
module alu_issue_seq #(
  parameter int MUL_CYCLES = 2,
  parameter int DIV_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  op,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
`ifdef ALU_ISSUE_SEQ_FLAGS_EN
  output logic        dbz,
  output logic [2:0]  flags
`else
  output logic        dbz
`endif
);

  // state | meaning
  // IDLE  | waiting for a request, in_ready high
  // EXEC  | operands latched, latency counter running
  // DONE  | result valid, waiting for out_ready

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  localparam logic [3:0] MUL_LAT_M1 = 4'(MUL_CYCLES - 1);
  localparam logic [3:0] DIV_LAT_M1 = 4'(DIV_CYCLES - 1);

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic [3:0]  lat_m1;
  logic        accept;
  logic        capture;

  logic [1:0]  op_q;
  logic [15:0] a_q;
  logic [15:0] b_q;

  logic [16:0] sum17;
  logic [16:0] diff17;
  logic [31:0] prod;
  logic [15:0] quot;
  logic        div_zero;
  logic [31:0] res_c;
  logic        dbz_c;

  logic [31:0] result_q;
  logic        dbz_q;

  always_comb begin
    lat_m1 = 4'd0;
    case (op)
      OP_MUL:  lat_m1 = MUL_LAT_M1;
      OP_DIV:  lat_m1 = DIV_LAT_M1;
      default: lat_m1 = 4'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    accept    = 1'b0;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        in_ready = ~rst;
        if (in_valid && !rst) begin
          accept    = 1'b1;
          state_nxt = EXEC;
          cnt_nxt   = lat_m1;
        end
      end
      EXEC: begin
        if (cnt == 4'd0) begin
          capture   = 1'b1;
          state_nxt = DONE;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath is combinational off the latched operands; it has LAT cycles to settle.
  always_comb begin
    sum17    = {1'b0, a_q} + {1'b0, b_q};
    diff17   = {1'b0, a_q} + {1'b0, ~b_q} + 17'd1;
    prod     = {16'd0, a_q} * {16'd0, b_q};
    div_zero = (b_q == 16'd0);
    quot     = div_zero ? 16'hFFFF : (a_q / b_q);
    res_c    = 32'd0;
    dbz_c    = 1'b0;
    case (op_q)
      OP_ADD: res_c = {15'd0, sum17};
      OP_SUB: res_c = {15'd0, diff17};
      OP_MUL: res_c = prod;
      OP_DIV: begin
        res_c = {16'd0, quot};
        dbz_c = div_zero;
      end
      default: res_c = 32'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q     <= OP_ADD;
      a_q      <= 16'd0;
      b_q      <= 16'd0;
      result_q <= 32'd0;
      dbz_q    <= 1'b0;
    end else begin
      if (accept) begin
        op_q <= op;
        a_q  <= a;
        b_q  <= b;
      end
      if (capture) begin
        result_q <= res_c;
        dbz_q    <= dbz_c;
      end
    end
  end

  assign result = result_q;
  assign dbz    = dbz_q;

`ifdef ALU_ISSUE_SEQ_FLAGS_EN
  logic       is_addsub;
  logic       ovf_c;
  logic [2:0] flags_c;
  logic [2:0] flags_q;

  // Signed overflow: operands agree in sign (ADD) or differ (SUB) and the result sign flips.
  always_comb begin
    is_addsub = (op_q == OP_ADD) || (op_q == OP_SUB);
    ovf_c     = 1'b0;
    if (op_q == OP_ADD)
      ovf_c = (a_q[15] == b_q[15]) && (sum17[15] != a_q[15]);
    else if (op_q == OP_SUB)
      ovf_c = (a_q[15] != b_q[15]) && (diff17[15] != a_q[15]);
    flags_c = {(res_c == 32'd0), (is_addsub & res_c[16]), ovf_c};
  end

  always_ff @(posedge clk) begin
    if (rst)          flags_q <= 3'd0;
    else if (capture) flags_q <= flags_c;
  end

  assign flags = flags_q;
`endif

endmodule
